// File: rtl/mix_tree_pkg.sv
// Shared types and helpers for the mixing-tree sequencer.
// The optional abort input is controlled by the MIX_TREE_ABORT_EN macro in the top.
package mix_tree_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_MIX   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Number of mixing levels for a tree with n leaf channels.
  function automatic int levels_of(input int n);
    return $clog2(n);
  endfunction

  // Bit index of node 0 of level k in the flat per-node valve vectors.
  function automatic int node_off(input int n, input int k);
    return n - (n >> k);
  endfunction

endpackage

// File: rtl/mix_tree_live.sv
// Combinational liveness tree: for every mixing node, reports whether both of
// its inputs carry fluid or exactly one of them does.
module mix_tree_live
  import mix_tree_pkg::*;
#(
  parameter int N_CH = 8
) (
  input  logic [N_CH-1:0] chan_mask,
  output logic [N_CH-2:0] both_live,
  output logic [N_CH-2:0] one_live
);

  localparam int LEVELS = levels_of(N_CH);

  // Leaves occupy [N_CH-1:0]; non-root nodes follow at N_CH + node index.
  // The root's own liveness is never consumed, so it is not stored.
  logic [2*N_CH-3:0] live;

  // Walk the tree level by level; each level only reads the one below it.
  always_comb begin
    live      = '0;
    both_live = '0;
    one_live  = '0;
    live[N_CH-1:0] = chan_mask;
    for (int k = 0; k < LEVELS; k++) begin
      for (int j = 0; j < N_CH / 2; j++) begin
        if (j < (N_CH >> (k + 1))) begin
          // Inputs of level k start at 2*N_CH - 2*(N_CH>>k) in the flat vector
          // (the leaves for k = 0, the level k-1 nodes otherwise).
          both_live[node_off(N_CH, k) + j] =
            live[2*N_CH - 2*(N_CH >> k) + 2*j] & live[2*N_CH - 2*(N_CH >> k) + 2*j + 1];
          one_live[node_off(N_CH, k) + j] =
            live[2*N_CH - 2*(N_CH >> k) + 2*j] ^ live[2*N_CH - 2*(N_CH >> k) + 2*j + 1];
          if (k < LEVELS - 1) begin
            live[N_CH + node_off(N_CH, k) + j] =
              live[2*N_CH - 2*(N_CH >> k) + 2*j] | live[2*N_CH - 2*(N_CH >> k) + 2*j + 1];
          end
        end
      end
    end
  end

endmodule

// File: rtl/mix_tree_sequencer.sv
// Valve sequencer for a binary mixing tree: fill the live inlets, mix level by
// level toward the root, flush the outlet, then pulse done.
// Define MIX_TREE_ABORT_EN to add the abort input (FILL/MIX jump to FLUSH).
//
//   state | meaning
//   IDLE  | waiting for a run request, start_ready high
//   FILL  | inlet valves of live channels open
//   MIX   | mix/bypass valves of the current tree level open, level 0..LEVELS-1
//   FLUSH | outlet valve open
//   DONE  | one-cycle completion pulse
module mix_tree_sequencer
  import mix_tree_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] fill_time,
  input  logic [CNT_W-1:0] mix_time,
  input  logic [CNT_W-1:0] flush_time,
  input  logic [N_CH-1:0]  chan_mask,
`ifdef MIX_TREE_ABORT_EN
  input  logic             abort,
`endif
  output logic [N_CH-1:0]  inlet_valve,
  output logic [N_CH-2:0]  mix_valve,
  output logic [N_CH-2:0]  bypass_valve,
  output logic             out_valve,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int LEVELS = levels_of(N_CH);
  localparam int LVL_W  = $clog2(LEVELS + 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] timer_q;
  logic [LVL_W-1:0] level_q;
  logic [CNT_W-1:0] mix_q;
  logic [CNT_W-1:0] flush_q;
  logic [N_CH-1:0]  mask_q;
  logic             cfg_err_q;

  logic             tc;
  logic             last_level;
  logic             accept;
  logic             abort_req;
  logic [N_CH-2:0]  both_live;
  logic [N_CH-2:0]  one_live;

  // A phase of duration d lasts max(d,1) cycles: load d-1 and end on zero.
  function automatic logic [CNT_W-1:0] eff_load(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  assign tc         = (timer_q == '0);
  assign last_level = (level_q == LVL_W'(LEVELS - 1));
  assign accept     = (state_q == ST_IDLE) && start_valid && (chan_mask != '0);

`ifdef MIX_TREE_ABORT_EN
  assign abort_req  = abort && ((state_q == ST_FILL) || (state_q == ST_MIX));
`else
  assign abort_req  = 1'b0;
`endif

  mix_tree_live #(.N_CH(N_CH)) u_live (
    .chan_mask (mask_q),
    .both_live (both_live),
    .one_live  (one_live)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; abort overrides the phase timer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_FILL;
      ST_FILL: begin
        if (abort_req)   state_d = ST_FLUSH;
        else if (tc)     state_d = ST_MIX;
      end
      ST_MIX: begin
        if (abort_req)               state_d = ST_FLUSH;
        else if (tc && last_level)   state_d = ST_FLUSH;
      end
      ST_FLUSH: if (tc) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Phase timer, level index, run parameters and the reject pulse.
  // The fill duration goes straight into the timer at acceptance, so it needs
  // no separate holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      level_q   <= '0;
      mix_q     <= '0;
      flush_q   <= '0;
      mask_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == ST_IDLE) && start_valid && (chan_mask == '0);
      if (accept) begin
        mask_q  <= chan_mask;
        mix_q   <= mix_time;
        flush_q <= flush_time;
        timer_q <= eff_load(fill_time);
        level_q <= '0;
      end else if ((state_d == ST_FLUSH) && (state_q != ST_FLUSH)) begin
        timer_q <= eff_load(flush_q);
      end else if ((state_d == ST_MIX) && ((state_q != ST_MIX) || tc)) begin
        timer_q <= eff_load(mix_q);
        level_q <= (state_q == ST_MIX) ? level_q + 1'b1 : '0;
      end else if (!tc) begin
        timer_q <= timer_q - 1'b1;
      end
    end
  end

  // Valve and status outputs; only the current level's node valves may open.
  always_comb begin
    inlet_valve  = '0;
    mix_valve    = '0;
    bypass_valve = '0;
    out_valve    = 1'b0;
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    case (state_q)
      ST_FILL:  inlet_valve = mask_q;
      ST_FLUSH: out_valve   = 1'b1;
      ST_MIX: begin
        for (int k = 0; k < LEVELS; k++) begin
          for (int j = 0; j < N_CH / 2; j++) begin
            if ((j < (N_CH >> (k + 1))) && (level_q == LVL_W'(k))) begin
              mix_valve[node_off(N_CH, k) + j]    = both_live[node_off(N_CH, k) + j];
              bypass_valve[node_off(N_CH, k) + j] = one_live[node_off(N_CH, k) + j];
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign start_ready = !busy;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_mix_tree_sequencer.sv
// Directed bench for mix_tree_sequencer: a 4-channel instance for the main
// timelines and an 8-channel instance for deeper-tree node indexing.
module tb_mix_tree_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sv4, sv8;
  logic [7:0] fill_time, mix_time, flush_time;
  logic [3:0] mask4;
  logic [7:0] mask8;
`ifdef MIX_TREE_ABORT_EN
  logic       abort;
`endif

  logic       sr4, busy4, done4, cfg4, out4;
  logic [3:0] inlet4;
  logic [2:0] mix4, byp4;
  logic       sr8, busy8, done8, cfg8, out8;
  logic [7:0] inlet8;
  logic [6:0] mix8, byp8;

  logic [14:0] st4;
  logic [26:0] st8;
  assign st4 = {sr4, busy4, done4, cfg4, out4, inlet4, mix4, byp4};
  assign st8 = {sr8, busy8, done8, cfg8, out8, inlet8, mix8, byp8};

  int n_chk  = 0;
  int n_pass = 0;

  mix_tree_sequencer #(.N_CH(4), .CNT_W(8)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (sv4),
    .start_ready  (sr4),
    .fill_time    (fill_time),
    .mix_time     (mix_time),
    .flush_time   (flush_time),
    .chan_mask    (mask4),
`ifdef MIX_TREE_ABORT_EN
    .abort        (abort),
`endif
    .inlet_valve  (inlet4),
    .mix_valve    (mix4),
    .bypass_valve (byp4),
    .out_valve    (out4),
    .busy         (busy4),
    .done         (done4),
    .cfg_err      (cfg4)
  );

  mix_tree_sequencer #(.N_CH(8), .CNT_W(8)) u_dut8 (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (sv8),
    .start_ready  (sr8),
    .fill_time    (fill_time),
    .mix_time     (mix_time),
    .flush_time   (flush_time),
    .chan_mask    (mask8),
`ifdef MIX_TREE_ABORT_EN
    .abort        (abort),
`endif
    .inlet_valve  (inlet8),
    .mix_valve    (mix8),
    .bypass_valve (byp8),
    .out_valve    (out8),
    .busy         (busy8),
    .done         (done8),
    .cfg_err      (cfg8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One 4-channel run; valve patterns per level are supplied by hand.
  // start_valid stays high through the run and inputs are scrambled after
  // acceptance, so any re-acceptance or unlatched field breaks the timeline.
  task automatic run4(input string tag, input logic [3:0] mask, input int f, input int m,
                      input int fl, input logic [2:0] m0, input logic [2:0] b0,
                      input logic [2:0] m1, input logic [2:0] b1);
    int ef, em, efl, total;
    logic [14:0] e;
    ef    = (f == 0) ? 1 : f;
    em    = (m == 0) ? 1 : m;
    efl   = (fl == 0) ? 1 : fl;
    total = ef + 2*em + efl + 1;
    mask4 = mask; fill_time = 8'(f); mix_time = 8'(m); flush_time = 8'(fl);
    sv4   = 1'b1;
    for (int c = 1; c <= total + 1; c++) begin
      step();
      if (c == 1) begin
        mask4 = 4'b0000; fill_time = 8'd9; mix_time = 8'd9; flush_time = 8'd9;
      end
      if (c <= ef)                    e = {5'b01000, mask, 3'b000, 3'b000};
      else if (c <= ef + em)          e = {5'b01000, 4'b0000, m0, b0};
      else if (c <= ef + 2*em)        e = {5'b01000, 4'b0000, m1, b1};
      else if (c <= ef + 2*em + efl)  e = {5'b01001, 10'b0};
      else if (c == total)            e = {5'b01100, 10'b0};
      else                            e = {5'b10000, 10'b0};
      chk($sformatf("%s c%0d", tag, c), 32'(st4), 32'(e));
      if (c == total) sv4 = 1'b0;
    end
  endtask

  // One 8-channel run with all durations zero: FILL, L0, L1, L2, FLUSH, DONE.
  task automatic run8(input string tag, input logic [7:0] mask,
                      input logic [6:0] m0, input logic [6:0] b0, input logic [6:0] m1,
                      input logic [6:0] b1, input logic [6:0] m2, input logic [6:0] b2);
    logic [26:0] e;
    mask8 = mask; fill_time = 8'd0; mix_time = 8'd0; flush_time = 8'd0;
    sv8   = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      case (c)
        1:       e = {5'b01000, mask, 7'b0, 7'b0};
        2:       e = {5'b01000, 8'b0, m0, b0};
        3:       e = {5'b01000, 8'b0, m1, b1};
        4:       e = {5'b01000, 8'b0, m2, b2};
        5:       e = {5'b01001, 22'b0};
        6:       e = {5'b01100, 22'b0};
        default: e = {5'b10000, 22'b0};
      endcase
      chk($sformatf("%s c%0d", tag, c), 32'(st8), 32'(e));
      if (c == 6) sv8 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sv4 = 1'b0; sv8 = 1'b0;
    fill_time = '0; mix_time = '0; flush_time = '0; mask4 = '0; mask8 = '0;
`ifdef MIX_TREE_ABORT_EN
    abort = 1'b0;
`endif
    step();
    step();
    chk("reset4", 32'(st4), 32'({5'b10000, 10'b0}));
    chk("reset8", 32'(st8), 32'({5'b10000, 22'b0}));
    rst = 1'b0;
    step();

    // Full mask, level 0 mixes both pairs, root mixes; done 10 cycles in.
    run4("full", 4'b1111, 3, 2, 2, 3'b011, 3'b000, 3'b100, 3'b000);
    // Single channel: pass-through at node 0 then root, node 1 stays closed.
    run4("single", 4'b0001, 1, 1, 1, 3'b000, 3'b001, 3'b000, 3'b100);
    // Three channels: mix at node 0, bypass at node 1, mix at root.
    run4("three", 4'b0111, 2, 1, 3, 3'b001, 3'b010, 3'b100, 3'b000);
    // Zero durations behave as one cycle each.
    run4("zero4", 4'b1000, 0, 0, 0, 3'b000, 3'b010, 3'b000, 3'b100);

    // Empty mask is rejected with a single cfg_err pulse.
    mask4 = 4'b0000; sv4 = 1'b1;
    step();
    sv4 = 1'b0;
    chk("cfgerr pulse", 32'(st4), 32'({5'b10010, 10'b0}));
    step();
    chk("cfgerr clear", 32'(st4), 32'({5'b10000, 10'b0}));

    // Deep tree, zero durations: done 6 cycles after acceptance.
    run8("full8", 8'hFF, 7'b0001111, 7'b0, 7'b0110000, 7'b0, 7'b1000000, 7'b0);
    run8("ends8", 8'b1000_0001, 7'b0, 7'b0001001, 7'b0, 7'b0110000, 7'b1000000, 7'b0);

    // Reset during MIX level 1 returns to IDLE at once with no done.
    mask4 = 4'b1111; fill_time = 8'd1; mix_time = 8'd2; flush_time = 8'd1; sv4 = 1'b1;
    step();
    sv4 = 1'b0;
    step(); step(); step();
    chk("rst pre mix L1", 32'(mix4), 32'(3'b100));
    rst = 1'b1;
    step();
    chk("rst midrun", 32'(st4), 32'({5'b10000, 10'b0}));
    rst = 1'b0;
    step();
    chk("rst after1", 32'(st4), 32'({5'b10000, 10'b0}));
    step();
    chk("rst after2", 32'(st4), 32'({5'b10000, 10'b0}));

`ifdef MIX_TREE_ABORT_EN
    // Abort in the second FILL cycle: FLUSH for 3 cycles, then one done.
    mask4 = 4'b1111; fill_time = 8'd5; mix_time = 8'd2; flush_time = 8'd3; sv4 = 1'b1;
    step();
    chk("abort c1", 32'(st4), 32'({5'b01000, 4'b1111, 6'b0}));
    step();
    chk("abort c2", 32'(st4), 32'({5'b01000, 4'b1111, 6'b0}));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort c3", 32'(st4), 32'({5'b01001, 10'b0}));
    step();
    chk("abort c4", 32'(st4), 32'({5'b01001, 10'b0}));
    step();
    chk("abort c5", 32'(st4), 32'({5'b01001, 10'b0}));
    step();
    chk("abort c6", 32'(st4), 32'({5'b01100, 10'b0}));
    sv4 = 1'b0;
    step();
    chk("abort c7", 32'(st4), 32'({5'b10000, 10'b0}));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
